// File: rtl/timer_arb_pkg.sv
// Shared types for the seconds-timer arbiter: FSM encoding and the default 1 Hz divider.
package timer_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_TICK_DIV = 100_000_000;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module rr_picker #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   // Walk from the farthest offset back to ptr so the nearest requester wins last.
   always_comb begin
      int i;
      idx = '0;
      vld = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         i = int'(ptr) + k;
         if (i >= NREQ) i = i - NREQ;
         if (req[i]) begin
            idx = IDX_W'(i);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sec_timer_arbiter.sv
// Round-robin owner of one shared seconds timer; counts the owner's duration down to a done pulse.
// Define TIMER_ARB_PRESCALE_EN to build an internal TICK_DIV divider in place of the tick input.
import timer_arb_pkg::*;

module sec_timer_arbiter #(
   parameter int NREQ     = 4,
   parameter int CNT_W    = 4,
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*CNT_W-1:0] dur,
   input  logic                  abort,
   input  logic                  tick,
   output logic                  timer_en,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [CNT_W-1:0]      remain,
   output logic                  flash
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   state_t                       state;
   logic [IDX_W-1:0]             rr_ptr, owner, win, nxt_ptr;
   logic                         win_vld, tick_c, cancel;
   logic [NREQ-1:0][CNT_W-1:0]   dur_a;

   assign dur_a   = dur;
   assign cancel  = abort | ~req[owner];
   assign nxt_ptr = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;

   rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .req (req),
      .ptr (rr_ptr),
      .idx (win),
      .vld (win_vld)
   );

`ifdef TIMER_ARB_PRESCALE_EN
   logic [31:0] div_cnt;

   assign tick_c = (state == COUNT) && (div_cnt == 32'(TICK_DIV - 1));

   // Divider only runs while counting so each grant starts a fresh second.
   always_ff @(posedge clk) begin
      if (rst || state != COUNT || tick_c) div_cnt <= '0;
      else                                 div_cnt <= div_cnt + 32'd1;
   end
`else
   assign tick_c = tick;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         grant    <= '0;
         done     <= '0;
         remain   <= '0;
         flash    <= 1'b0;
         timer_en <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= '0;
               if (win_vld) begin
                  owner  <= win;
                  grant  <= ONE << win;
                  remain <= dur_a[win];
                  busy   <= 1'b1;
                  if (dur_a[win] != '0) begin
                     state    <= COUNT;
                     timer_en <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= ONE << win;
                  end
               end
            end
            COUNT: begin
               // Cancel has priority over a coincident tick.
               if (cancel) begin
                  state    <= IDLE;
                  grant    <= '0;
                  remain   <= '0;
                  flash    <= 1'b0;
                  timer_en <= 1'b0;
                  busy     <= 1'b0;
                  rr_ptr   <= nxt_ptr;
               end else if (tick_c) begin
                  if (remain == CNT_W'(1)) begin
                     state    <= DONE;
                     remain   <= '0;
                     flash    <= 1'b0;
                     timer_en <= 1'b0;
                     done     <= grant;
                  end else begin
                     remain <= remain - 1'b1;
                     flash  <= ~flash;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               done   <= '0;
               grant  <= '0;
               busy   <= 1'b0;
               rr_ptr <= nxt_ptr;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
